// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - single-outstanding instruction fetcher between memory controller and instruction queue
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [31:0] redirect_pc,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  input  logic        iq_full,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc
);

  // IDLE: no request; BUSY: live request; HOLD: word waiting for queue space;
  // DRAIN: request whose data must be dropped because a redirect arrived.
  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        mc_req_q, mc_req_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic        iq_valid_q, iq_valid_d;
  logic [31:0] iq_inst_q, iq_inst_d;
  logic [31:0] iq_pc_q, iq_pc_d;

  assign mc_req   = mc_req_q;
  assign mc_addr  = mc_addr_q;
  assign iq_valid = iq_valid_q;
  assign iq_inst  = iq_inst_q;
  assign iq_pc    = iq_pc_q;

  // Next-state and registered-output logic; rdy=0 leaves every register as is.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    mc_req_d   = mc_req_q;
    mc_addr_d  = mc_addr_q;
    iq_valid_d = iq_valid_q;
    iq_inst_d  = iq_inst_q;
    iq_pc_d    = iq_pc_q;

    if (rdy) begin
      // The push strobe only ever lasts one active cycle.
      iq_valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (clear) begin
            pc_d = redirect_pc;
          end else if (!iq_full) begin
            mc_req_d  = 1'b1;
            mc_addr_d = pc_q;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (mc_done) begin
            mc_req_d = 1'b0;
            if (clear) begin
              pc_d    = redirect_pc;
              state_d = IDLE;
            end else if (!iq_full) begin
              iq_valid_d = 1'b1;
              iq_inst_d  = mc_data;
              iq_pc_d    = pc_q;
              pc_d       = pc_q + 32'd4;
              state_d    = IDLE;
            end else begin
              hold_d  = mc_data;
              state_d = HOLD;
            end
          end else if (clear) begin
            // The memory controller still owes a response; keep the request up.
            pc_d    = redirect_pc;
            state_d = DRAIN;
          end
        end
        HOLD: begin
          if (clear) begin
            pc_d    = redirect_pc;
            hold_d  = '0;
            state_d = IDLE;
          end else if (!iq_full) begin
            iq_valid_d = 1'b1;
            iq_inst_d  = hold_q;
            iq_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
            hold_d     = '0;
            state_d    = IDLE;
          end
        end
        DRAIN: begin
          if (clear) begin
            pc_d = redirect_pc;
          end
          if (mc_done) begin
            mc_req_d = 1'b0;
            state_d  = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      hold_q     <= '0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= '0;
      iq_valid_q <= 1'b0;
      iq_inst_q  <= '0;
      iq_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      mc_req_q   <= mc_req_d;
      mc_addr_q  <= mc_addr_d;
      iq_valid_q <= iq_valid_d;
      iq_inst_q  <= iq_inst_d;
      iq_pc_q    <= iq_pc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - directed and randomized checks of inst_fetcher against a transaction model
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, mc_done, iq_full, mc_done2;
  logic [31:0] redirect_pc, mc_data, mc_data2;
  logic        mc_req, iq_valid, mc_req2, iq_valid2;
  logic [31:0] mc_addr, iq_inst, iq_pc, mc_addr2, iq_inst2, iq_pc2;

  int tests = 0;
  int fails = 0;

  // Transaction-level model state for the randomized phase.
  logic        m_out, m_live, m_held, e_valid;
  logic [31:0] m_addr, m_pc, m_hdata, e_inst, e_pc;
  int          m_cnt;

  always #5 clk = ~clk;

  inst_fetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .redirect_pc(redirect_pc),
    .mc_req(mc_req), .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data),
    .iq_full(iq_full), .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc)
  );

  inst_fetcher #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(1'b0), .redirect_pc(32'h0),
    .mc_req(mc_req2), .mc_addr(mc_addr2), .mc_done(mc_done2), .mc_data(mc_data2),
    .iq_full(1'b0), .iq_valid(iq_valid2), .iq_inst(iq_inst2), .iq_pc(iq_pc2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; redirect_pc = '0;
    mc_done = 1'b0; mc_data = '0; iq_full = 1'b0; mc_done2 = 1'b0; mc_data2 = '0;

    // Reset values
    #2;
    chk("rst_req", mc_req, 0);
    chk("rst_addr", mc_addr, 0);
    chk("rst_valid", iq_valid, 0);
    chk("rst_inst", iq_inst, 0);
    chk("rst_pc", iq_pc, 0);
    tick(); tick();
    chk("rst_hold_req", mc_req, 0);
    rst = 1'b1;

    // First fetch at RESET_PC, memory answers two cycles after the request
    tick();
    chk("first_req", mc_req, 1);
    chk("first_addr", mc_addr, 32'h0);
    chk("wrap_req", mc_req2, 1);
    chk("wrap_addr", mc_addr2, 32'hFFFF_FFFC);
    tick();
    chk("busy_req", mc_req, 1);
    chk("busy_novalid", iq_valid, 0);
    mc_done = 1'b1; mc_data = 32'h0000_0013; mc_done2 = 1'b1; mc_data2 = 32'h1111_2222;
    tick();
    chk("push_valid", iq_valid, 1);
    chk("push_inst", iq_inst, 32'h0000_0013);
    chk("push_pc", iq_pc, 32'h0);
    chk("push_noreq", mc_req, 0);
    chk("wrap_push_valid", iq_valid2, 1);
    chk("wrap_push_pc", iq_pc2, 32'hFFFF_FFFC);
    mc_done = 1'b0; mc_done2 = 1'b0;
    tick();
    chk("pulse_end", iq_valid, 0);
    chk("next_req", mc_req, 1);
    chk("next_addr", mc_addr, 32'h4);
    chk("wrap_next_addr", mc_addr2, 32'h0);

    // Queue full at completion: word held, pushed once space appears
    iq_full = 1'b1; mc_done = 1'b1; mc_data = 32'hDEAD_BEEF;
    tick();
    chk("hold_novalid", iq_valid, 0);
    chk("hold_noreq", mc_req, 0);
    mc_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("hold_wait_valid", iq_valid, 0);
      chk("hold_wait_req", mc_req, 0);
    end
    iq_full = 1'b0;
    tick();
    chk("hold_push_valid", iq_valid, 1);
    chk("hold_push_inst", iq_inst, 32'hDEAD_BEEF);
    chk("hold_push_pc", iq_pc, 32'h4);
    tick();
    chk("hold_after_valid", iq_valid, 0);
    chk("hold_after_addr", mc_addr, 32'h8);

    // Redirect while busy: request kept until done, data dropped
    clear = 1'b1; redirect_pc = 32'h0000_1000;
    tick();
    chk("drain_req", mc_req, 1);
    chk("drain_addr", mc_addr, 32'h8);
    clear = 1'b0;
    tick();
    chk("drain_req2", mc_req, 1);
    chk("drain_addr2", mc_addr, 32'h8);
    mc_done = 1'b1; mc_data = 32'h1234_5678;
    tick();
    chk("drain_novalid", iq_valid, 0);
    chk("drain_done_req", mc_req, 0);
    mc_done = 1'b0;
    tick();
    chk("redir_req", mc_req, 1);
    chk("redir_addr", mc_addr, 32'h1000);
    chk("redir_novalid", iq_valid, 0);

    // Redirect coincident with completion
    clear = 1'b1; redirect_pc = 32'h0000_2000; mc_done = 1'b1; mc_data = 32'h5555_AAAA;
    tick();
    chk("coinc_novalid", iq_valid, 0);
    chk("coinc_noreq", mc_req, 0);
    clear = 1'b0; mc_done = 1'b0;
    tick();
    chk("coinc_addr", mc_addr, 32'h2000);
    chk("coinc_novalid2", iq_valid, 0);

    // rdy low freezes; mc_done during rdy low is ignored
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin mc_done = 1'b1; mc_data = 32'hBAD0_BAD0; end
      tick();
      chk("frz_req", mc_req, 1);
      chk("frz_addr", mc_addr, 32'h2000);
      chk("frz_valid", iq_valid, 0);
    end
    rdy = 1'b1; mc_done = 1'b0;
    tick();
    chk("frz_after_valid", iq_valid, 0);
    chk("frz_after_req", mc_req, 1);
    mc_done = 1'b1; mc_data = 32'h0000_CAFE;
    tick();
    chk("frz_push_valid", iq_valid, 1);
    chk("frz_push_inst", iq_inst, 32'h0000_CAFE);
    chk("frz_push_pc", iq_pc, 32'h2000);
    mc_done = 1'b0; rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("frz_pulse_held", iq_valid, 1);
      chk("frz_pulse_noreq", mc_req, 0);
    end
    rdy = 1'b1;
    tick();
    chk("frz_end_valid", iq_valid, 0);
    chk("frz_end_addr", mc_addr, 32'h2004);

    // Reset mid-fetch, stale mc_done afterwards, queue full in IDLE
    rst = 1'b0;
    #1;
    chk("arst_req", mc_req, 0);
    chk("arst_addr", mc_addr, 0);
    iq_full = 1'b1; mc_done = 1'b1; mc_data = 32'hBAD1_BAD1;
    tick();
    rst = 1'b1;
    tick();
    chk("stale_noreq", mc_req, 0);
    chk("stale_novalid", iq_valid, 0);
    mc_done = 1'b0;
    tick();
    chk("full_idle_noreq", mc_req, 0);
    iq_full = 1'b0;
    tick();
    chk("post_rst_req", mc_req, 1);
    chk("post_rst_addr", mc_addr, 32'h0);

    // Randomized phase against transaction model
    m_out = 1'b1; m_live = 1'b1; m_addr = 32'h0; m_pc = 32'h0; m_held = 1'b0;
    m_hdata = '0; m_cnt = 1; e_valid = 1'b0; e_inst = '0; e_pc = '0;
    for (int i = 0; i < 600; i++) begin
      rdy         = ($urandom_range(7) != 0);
      iq_full     = ($urandom_range(3) == 0);
      clear       = ($urandom_range(15) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      mc_done     = m_out && (m_cnt == 0);
      mc_data     = mc_done ? mem_word(m_addr) : $urandom;
      if (rdy) begin
        e_valid = 1'b0;
        if (clear) begin
          if (mc_done) m_out = 1'b0;
          m_live = 1'b0;
          m_held = 1'b0;
          m_pc   = redirect_pc;
        end else if (mc_done) begin
          m_out = 1'b0;
          if (m_live) begin
            if (!iq_full) begin
              e_valid = 1'b1; e_inst = mc_data; e_pc = m_pc; m_pc = m_pc + 32'd4;
            end else begin
              m_held = 1'b1; m_hdata = mc_data;
            end
          end
        end else if (m_held) begin
          if (!iq_full) begin
            e_valid = 1'b1; e_inst = m_hdata; e_pc = m_pc; m_pc = m_pc + 32'd4;
            m_held = 1'b0;
          end
        end else if (!m_out) begin
          if (!iq_full) begin
            m_out = 1'b1; m_live = 1'b1; m_addr = m_pc; m_cnt = $urandom_range(3);
          end
        end else if (m_cnt > 0) begin
          m_cnt--;
        end
      end
      tick();
      chk("rnd_valid", iq_valid, e_valid);
      if (e_valid) begin
        chk("rnd_inst", iq_inst, e_inst);
        chk("rnd_pc", iq_pc, e_pc);
      end
      chk("rnd_req", mc_req, m_out);
      if (m_out) chk("rnd_addr", mc_addr, m_addr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port rdy, input, 1, global ready; low freezes all state.
REQ-005 SHALL have port clear, input, 1, pipeline flush / redirect request.
REQ-006 SHALL have port redirect_pc, input, 32, new fetch address, sampled when clear=1.
REQ-007 SHALL have port mc_req, output, 1, instruction read request to the memory controller.
REQ-008 SHALL have port mc_addr, output, 32, word address of the request.
REQ-009 SHALL have port mc_done, input, 1, one-cycle pulse: read complete, mc_data valid.
REQ-010 SHALL have port mc_data, input, 32, fetched instruction word.
REQ-011 SHALL have port iq_full, input, 1, instruction queue full flag.
REQ-012 SHALL have port iq_valid, output, 1, one-cycle push strobe to the instruction queue.
REQ-013 SHALL have port iq_inst, output, 32, instruction pushed.
REQ-014 SHALL have port iq_pc, output, 32, address of the pushed instruction.

Function
REQ-015 SHALL implement a state machine with states IDLE, BUSY, HOLD, DRAIN.
REQ-016 SHALL keep a 32-bit fetch register pc; increments are pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 IDLE, clear=0, iq_full=0: SHALL assert mc_req, drive mc_addr=pc, enter BUSY next cycle.
REQ-018 IDLE, iq_full=1: SHALL stay IDLE with mc_req=0; no request issued.
REQ-019 BUSY: SHALL hold mc_req=1 and mc_addr stable until the cycle mc_done=1.
REQ-020 BUSY, mc_done=1, clear=0, iq_full=0: SHALL push next cycle (iq_valid=1, iq_inst=mc_data, iq_pc=pc), set pc=pc+4, return to IDLE.
REQ-021 BUSY, mc_done=1, clear=0, iq_full=1: SHALL latch mc_data into a one-entry hold buffer, enter HOLD, deassert mc_req.
REQ-022 HOLD: SHALL push the held word with iq_pc=pc in the first cycle iq_full=0, set pc=pc+4, return to IDLE.
REQ-023 iq_valid SHALL be a single-cycle pulse; exactly one push per completed, non-discarded fetch.
REQ-024 Push latency SHALL be one cycle after mc_done; a new request SHALL NOT issue in the push cycle (back-to-back minimum gap one cycle).
REQ-025 clear=1 in any state SHALL load pc=redirect_pc and force iq_valid=0 in the following cycle.
REQ-026 clear in IDLE or HOLD: hold buffer discarded, next state IDLE.
REQ-027 clear in BUSY with mc_done=0: SHALL enter DRAIN, keep mc_req=1 with the original mc_addr until mc_done.
REQ-028 DRAIN, mc_done=1: SHALL discard mc_data, no push, enter IDLE; clear again in DRAIN reloads pc, stays DRAIN.
REQ-029 clear and mc_done in the same BUSY cycle: SHALL discard the data, enter IDLE, no push.
REQ-030 rdy=0: SHALL hold every register and output unchanged; mc_done/clear sampled only when rdy=1.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, pc=RESET_PC, mc_req=0, mc_addr=0, iq_valid=0, iq_inst=0, iq_pc=0, hold buffer empty.
REQ-032 Reset mid-fetch SHALL abandon the in-flight request; a stale mc_done after release SHALL be ignored in IDLE.
REQ-033 First request SHALL issue in the first rdy=1 edge after rst deasserts with iq_full=0.

Verification
REQ-034 Reset, iq_full=0, memory returns 32'h0000_0013 two cycles after req -> mc_addr=0, push iq_pc=0, next mc_addr=4.
REQ-035 iq_full=1 at mc_done with data 32'hDEADBEEF -> HOLD, no push; iq_full falls 3 cycles later -> one push 32'hDEADBEEF, iq_pc correct.
REQ-036 clear with redirect_pc=32'h0000_1000 while BUSY -> mc_req held to mc_done, data dropped, next mc_addr=32'h1000.
REQ-037 clear coincident with mc_done -> no iq_valid; next request mc_addr=redirect_pc.
REQ-038 RESET_PC=32'hFFFF_FFFC, one fetch -> iq_pc=32'hFFFF_FFFC, next mc_addr=0.
REQ-039 rdy low 5 cycles during BUSY with mc_done high only while rdy low -> no state change, no push until mc_done seen with rdy=1.
